// File: rtl/dcache_2way_wt.sv
// Two-way set-associative write-through data cache.
// Hits answer combinationally; misses and stores handshake with memory.
module dcache_2way_wt #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int SET_BITS      = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ADDRESS_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0]    wdata,
    input  logic                     RE,
    input  logic                     WE,
    input  logic                     ByteOp,
    output logic [DATA_WIDTH-1:0]    rdata,
    output logic                     stall,
    output logic                     mem_req,
    output logic                     mem_we,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]    mem_wdata,
    output logic [3:0]               mem_be,
    input  logic [DATA_WIDTH-1:0]    mem_rdata,
    input  logic                     mem_ack
);

    localparam int SETS  = 1 << SET_BITS;
    localparam int TAG_W = ADDRESS_WIDTH - SET_BITS - 2;

    typedef enum logic [1:0] {IDLE, READ, FILL, WRITE} state_t;

    state_t state, state_nx;

    logic [SETS-1:0][1:0]    valid;
    logic [SETS-1:0]         lru;
    logic [TAG_W-1:0]        tag_mem  [SETS][2];
    logic [DATA_WIDTH-1:0]   data_mem [SETS][2];

    logic [ADDRESS_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0]    wdata_q;
    logic                     byte_q;

    logic                     is_load, is_store;
    logic [ADDRESS_WIDTH-1:0] cur_addr;
    logic                     cur_byte;
    logic [SET_BITS-1:0]      idx;
    logic [TAG_W-1:0]         tg;
    logic [1:0]               lane;
    logic                     hit0, hit1, hit, hit_way, victim;
    logic [DATA_WIDTH-1:0]    hit_word, load_val;
    logic [3:0]               be_q;
    logic [DATA_WIDTH-1:0]    wrep, mask, merged;
    logic                     fill_en, st_hit_en, ld_hit_en;

    // A store wins when both request lines are high.
    assign is_store = WE;
    assign is_load  = RE & ~WE;

    // New requests look up the live address; in-flight ones use the latched copy.
    assign cur_addr = (state == IDLE) ? addr : addr_q;
    assign cur_byte = (state == IDLE) ? ByteOp : byte_q;
    assign idx      = cur_addr[SET_BITS+1:2];
    assign tg       = cur_addr[ADDRESS_WIDTH-1:SET_BITS+2];
    assign lane     = cur_addr[1:0];

    assign hit0     = valid[idx][0] && (tag_mem[idx][0] == tg);
    assign hit1     = valid[idx][1] && (tag_mem[idx][1] == tg);
    assign hit      = hit0 | hit1;
    assign hit_way  = hit1;
    assign hit_word = hit1 ? data_mem[idx][1] : data_mem[idx][0];
    assign load_val = cur_byte ? {24'b0, hit_word[{lane, 3'b000} +: 8]}
                               : hit_word;

    // Prefer an empty way; otherwise evict the way the LRU bit names.
    assign victim = !valid[idx][0] ? 1'b0 :
                    !valid[idx][1] ? 1'b1 : lru[idx];

    assign be_q   = byte_q ? (4'b0001 << addr_q[1:0]) : 4'b1111;
    assign wrep   = byte_q ? {4{wdata_q[7:0]}} : wdata_q;
    assign mask   = {{8{be_q[3]}}, {8{be_q[2]}}, {8{be_q[1]}}, {8{be_q[0]}}};
    assign merged = (hit_word & ~mask) | (wrep & mask);

    assign fill_en   = (state == READ) && mem_ack;
    assign st_hit_en = (state == WRITE) && mem_ack && hit;
    assign ld_hit_en = (state == IDLE) && is_load && hit;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state decode.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (is_store)             state_nx = WRITE;
                else if (is_load && !hit) state_nx = READ;
            end
            READ:  if (mem_ack) state_nx = FILL;
            FILL:  state_nx = IDLE;
            WRITE: if (mem_ack) state_nx = IDLE;
        endcase
    end

    // Output decode; reset forces every output low.
    always_comb begin
        rdata     = '0;
        stall     = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_be    = 4'b0000;
        unique case (state)
            IDLE: begin
                if (is_store)     stall = 1'b1;
                else if (is_load) begin
                    if (hit) rdata = load_val;
                    else     stall = 1'b1;
                end
            end
            READ: begin
                mem_req  = 1'b1;
                mem_addr = {addr_q[ADDRESS_WIDTH-1:2], 2'b00};
                stall    = 1'b1;
            end
            FILL: if (hit) rdata = load_val;
            WRITE: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {addr_q[ADDRESS_WIDTH-1:2], 2'b00};
                mem_wdata = wrep;
                mem_be    = be_q;
                stall     = ~mem_ack;
            end
        endcase
        if (rst) begin
            stall = 1'b0;
            rdata = '0;
        end
    end

    // Capture the request so memory-side outputs stay constant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q  <= '0;
            wdata_q <= '0;
            byte_q  <= 1'b0;
        end else if (state == IDLE && (RE || WE)) begin
            addr_q  <= addr;
            wdata_q <= wdata;
            byte_q  <= ByteOp;
        end
    end

    // Valid and LRU bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= '0;
            lru   <= '0;
        end else if (fill_en) begin
            valid[idx][victim] <= 1'b1;
            lru[idx]           <= ~victim;
        end else if (ld_hit_en || st_hit_en) begin
            lru[idx] <= ~hit_way;
        end
    end

    // Tag and data arrays: refill on read ack, merge on store hit.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_mem[idx][victim]  <= tg;
            data_mem[idx][victim] <= mem_rdata;
        end else if (st_hit_en) begin
            data_mem[idx][hit_way] <= merged;
        end
    end

endmodule

// File: tb/tb_dcache_2way_wt.sv
// Randomised bench for dcache_2way_wt against a set-wise MRU-list model
// and a sparse memory image.
module tb_dcache_2way_wt;

    logic        clk;
    logic        rst;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        RE;
    logic        WE;
    logic        ByteOp;
    logic [31:0] rdata;
    logic        stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    int total;
    int bad;

    logic [31:0] mem [logic [31:0]];
    logic [29:0] sq [8][$];

    dcache_2way_wt dut (
        .clk       (clk),
        .rst       (rst),
        .addr      (addr),
        .wdata     (wdata),
        .RE        (RE),
        .WE        (WE),
        .ByteOp    (ByteOp),
        .rdata     (rdata),
        .stall     (stall),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mrd(input logic [31:0] w);
        if (mem.exists(w)) return mem[w];
        return (w * 32'h9E3779B1) ^ 32'hA5A50F0F;
    endfunction

    task automatic model_clear();
        for (int s = 0; s < 8; s++) sq[s].delete();
    endtask

    // One CPU access, held until the cache releases stall.
    task automatic access(input bit st, input bit both,
                          input logic [31:0] a, input logic [31:0] wd,
                          input bit bop, input int k);
        logic [29:0] w;
        int          s;
        int          pos;
        bit          hit;
        int          nst;
        logic [31:0] word, exp_rd, ewd, msk, lanev;
        logic [3:0]  ebe;
        w     = a[31:2];
        s     = int'(a[4:2]);
        pos   = -1;
        for (int i = 0; i < sq[s].size(); i++)
            if (sq[s][i] == w) pos = i;
        hit   = (pos >= 0);
        word  = mrd({w, 2'b00});
        lanev = 32'(a[1:0]) * 8;
        exp_rd = bop ? ((word >> lanev) & 32'hFF) : word;
        ebe   = bop ? 4'(4'b0001 << a[1:0]) : 4'b1111;
        ewd   = bop ? (wd & 32'hFF) * 32'h01010101 : wd;
        RE     = !st || both;
        WE     = st;
        addr   = a;
        wdata  = wd;
        ByteOp = bop;
        nst    = 0;
        @(negedge clk);
        if (stall) nst++;
        if (!st) check("hit", 32'(!stall), 32'(hit));
        if (!st && hit) begin
            check("hit_rd", rdata, exp_rd);
            check("hit_req", 32'(mem_req), 32'd0);
            sq[s].delete(pos);
            sq[s].push_front(w);
            @(posedge clk); #1;
        end else begin
            check("idle_req", 32'(mem_req), 32'd0);
            @(posedge clk); #1;
            for (int c = 1; c <= k; c++) begin
                if (c == k) begin
                    mem_ack   = 1'b1;
                    mem_rdata = st ? 32'h0 : word;
                end
                @(negedge clk);
                if (stall) nst++;
                check("req", 32'(mem_req), 32'd1);
                check("we", 32'(mem_we), 32'(st));
                check("maddr", mem_addr, {w, 2'b00});
                if (st) begin
                    check("be", 32'(mem_be), 32'(ebe));
                    check("wdat", mem_wdata, ewd);
                end
                @(posedge clk); #1;
                mem_ack   = 1'b0;
                mem_rdata = 32'h0;
            end
            if (st) begin
                msk = bop ? (32'hFF << lanev) : 32'hFFFFFFFF;
                mem[{w, 2'b00}] = (word & ~msk) | ((ewd) & msk);
                if (hit) begin
                    sq[s].delete(pos);
                    sq[s].push_front(w);
                end
                check("st_stalls", 32'(nst), 32'(k));
            end else begin
                sq[s].push_front(w);
                if (sq[s].size() > 2) void'(sq[s].pop_back());
                @(negedge clk);
                check("fill_stall", 32'(stall), 32'd0);
                check("fill_rd", rdata, exp_rd);
                check("ld_stalls", 32'(nst), 32'(k + 1));
                @(posedge clk); #1;
            end
        end
        RE     = 1'b0;
        WE     = 1'b0;
        ByteOp = 1'b0;
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        clk       = 1'b0;
        rst       = 1'b1;
        addr      = 32'h40;
        wdata     = 32'h0;
        RE        = 1'b1;
        WE        = 1'b0;
        ByteOp    = 1'b0;
        mem_rdata = 32'h0;
        mem_ack   = 1'b0;
        model_clear();
        mem[32'h40] = 32'hDEADBEEF;
        mem[32'h80] = 32'h11223344;

        @(posedge clk);
        @(posedge clk); #1;
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_req", 32'(mem_req), 32'd0);
        check("rst_we", 32'(mem_we), 32'd0);
        check("rst_be", 32'(mem_be), 32'd0);
        rst = 1'b0;
        RE  = 1'b0;
        @(posedge clk); #1;

        access(0, 0, 32'h40, 32'h0, 0, 2);
        access(0, 0, 32'h40, 32'h0, 0, 1);

        access(0, 0, 32'h000, 32'h0, 0, 1);
        access(0, 0, 32'h020, 32'h0, 0, 3);
        access(0, 0, 32'h000, 32'h0, 0, 1);
        access(0, 0, 32'h040, 32'h0, 0, 1);
        access(0, 0, 32'h000, 32'h0, 0, 1);
        access(0, 0, 32'h020, 32'h0, 0, 2);

        access(0, 0, 32'h80, 32'h0, 0, 1);
        access(1, 0, 32'h82, 32'h123456AA, 1, 2);
        access(0, 0, 32'h80, 32'h0, 0, 1);
        access(0, 0, 32'h83, 32'h0, 1, 1);

        access(1, 0, 32'h100, 32'h55555555, 0, 1);
        access(0, 0, 32'h100, 32'h0, 0, 2);

        access(1, 1, 32'h40, 32'hCAFEF00D, 0, 2);
        access(0, 0, 32'h40, 32'h0, 0, 1);

        RE   = 1'b1;
        addr = 32'h200;
        @(posedge clk); #1;
        @(negedge clk);
        check("pre_rst_req", 32'(mem_req), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("arst_req", 32'(mem_req), 32'd0);
        check("arst_stall", 32'(stall), 32'd0);
        RE = 1'b0;
        @(posedge clk); #1;
        rst       = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 32'hBAD0BAD0;
        @(negedge clk);
        check("late_ack_req", 32'(mem_req), 32'd0);
        check("late_ack_stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        model_clear();
        access(0, 0, 32'h40, 32'h0, 0, 1);

        for (int n = 0; n < 300; n++) begin
            logic [31:0] a, tv;
            int  t;
            bit  st, bop, both;
            t    = $urandom_range(0, 3);
            tv   = (t == 3) ? 32'h80000000 : 32'(t) << 5;
            st   = ($urandom_range(0, 2) == 0);
            bop  = $urandom_range(0, 1) == 1;
            both = st && ($urandom_range(0, 3) == 0);
            a    = tv | (32'($urandom_range(0, 7)) << 2);
            if (bop) a = a | 32'($urandom_range(0, 3));
            access(st, both, a, $urandom, bop, $urandom_range(1, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
